// File: rtl/detector_jogada.sv
// Button input conditioning for the memory game: synchronizes, debounces and
// validates single-button presses, giving one play strobe per physical press.
module detector_jogada #(
   parameter int N_BOTOES        = 4,
   parameter int DEBOUNCE_CICLOS = 20
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                habilita,
   input  logic [N_BOTOES-1:0] botoes,
   output logic [N_BOTOES-1:0] jogada,
   output logic                tem_jogada,
   output logic                jogada_invalida,
   output logic                ocupado,
   output logic [2:0]          db_estado
);

   // state         | meaning
   // LIVRE         | idle, waiting for a debounced press
   // EMITE         | valid one-hot press accepted, tem_jogada high
   // INVALIDO      | multi-button press seen, jogada_invalida high
   // ESPERA_SOLTAR | waiting for every button to be released
   localparam logic [2:0] LIVRE         = 3'b000;
   localparam logic [2:0] EMITE         = 3'b001;
   localparam logic [2:0] INVALIDO      = 3'b010;
   localparam logic [2:0] ESPERA_SOLTAR = 3'b011;

   localparam int             CW    = $clog2(DEBOUNCE_CICLOS + 1);
   localparam logic [CW-1:0]  C_FIM = CW'(DEBOUNCE_CICLOS - 1);

   logic [N_BOTOES-1:0] meta;
   logic [N_BOTOES-1:0] s;
   logic [N_BOTOES-1:0] d;
   logic [CW-1:0]       c [N_BOTOES];
   logic [2:0]          estado;
   logic                d_um_so;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta <= '0;
         s    <= '0;
      end else begin
         meta <= botoes;
         s    <= meta;
      end
   end

   // Each bit needs DEBOUNCE_CICLOS consecutive disagreeing samples to flip.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         d <= '0;
         for (int i = 0; i < N_BOTOES; i++) c[i] <= '0;
      end else begin
         for (int i = 0; i < N_BOTOES; i++) begin
            if (s[i] == d[i]) begin
               c[i] <= '0;
            end else if (c[i] == C_FIM) begin
               d[i] <= s[i];
               c[i] <= '0;
            end else begin
               c[i] <= c[i] + CW'(1);
            end
         end
      end
   end

   assign d_um_so = (d != '0) && ((d & (d - N_BOTOES'(1))) == '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado <= LIVRE;
         jogada <= '0;
      end else begin
         case (estado)
            LIVRE: begin
               if (d != '0) begin
                  if (!habilita) begin
                     estado <= ESPERA_SOLTAR;
                  end else if (d_um_so) begin
                     jogada <= d;
                     estado <= EMITE;
                  end else begin
                     estado <= INVALIDO;
                  end
               end
            end
            EMITE:         estado <= ESPERA_SOLTAR;
            INVALIDO:      estado <= ESPERA_SOLTAR;
            ESPERA_SOLTAR: if (d == '0) estado <= LIVRE;
            default:       estado <= LIVRE;
         endcase
      end
   end

   assign tem_jogada      = (estado == EMITE);
   assign jogada_invalida = (estado == INVALIDO);
   assign ocupado         = (estado != LIVRE);
   assign db_estado       = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada: directed scenarios plus a randomized run checked
// cycle by cycle against a behavioural model built from press/release rules.
module tb_detector_jogada;

   localparam int DB = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       habilita = 1'b0;
   logic [3:0] botoes = 4'b0000;
   logic [3:0] jogada;
   logic       tem_jogada;
   logic       jogada_invalida;
   logic       ocupado;
   logic [2:0] db_estado;

   int n_total = 0;
   int n_pass  = 0;

   detector_jogada #(.N_BOTOES(4), .DEBOUNCE_CICLOS(DB)) dut (
      .clock           (clock),
      .reset           (reset),
      .habilita        (habilita),
      .botoes          (botoes),
      .jogada          (jogada),
      .tem_jogada      (tem_jogada),
      .jogada_invalida (jogada_invalida),
      .ocupado         (ocupado),
      .db_estado       (db_estado)
   );

   always #5 clock = ~clock;

   // Strobe monitor: counts pulses, records play codes, flags overlap/repeat.
   int         tem_cnt = 0;
   int         inv_cnt = 0;
   int         viol    = 0;
   logic       prev_strobe = 1'b0;
   logic [3:0] codes [$];

   always @(posedge clock) begin
      #1;
      if (tem_jogada) begin
         tem_cnt++;
         codes.push_back(jogada);
      end
      if (jogada_invalida) inv_cnt++;
      if ((tem_jogada && jogada_invalida) || ((tem_jogada || jogada_invalida) && prev_strobe)) viol++;
      prev_strobe = tem_jogada | jogada_invalida;
   end

   // Reference model: a bit flips once the last DB synchronized samples all
   // disagree with it; a press is judged on the first non-zero debounced value.
   logic [3:0] ms1, ms2, dm, m_jog;
   logic [3:0] sh [$];
   logic       m_wait, m_tem, m_inv;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         ms1 = '0; ms2 = '0; dm = '0; m_jog = '0;
         m_wait = 1'b0; m_tem = 1'b0; m_inv = 1'b0;
         sh.delete();
      end else begin
         if (m_tem || m_inv) begin
            m_tem = 1'b0; m_inv = 1'b0; m_wait = 1'b1;
         end else if (m_wait) begin
            if (dm == 4'b0000) m_wait = 1'b0;
         end else if (dm != 4'b0000) begin
            if (!habilita) m_wait = 1'b1;
            else if ($countones(dm) == 1) begin
               m_jog = dm; m_tem = 1'b1;
            end else m_inv = 1'b1;
         end
         sh.push_back(ms2);
         if (sh.size() > DB) void'(sh.pop_front());
         if (sh.size() == DB) begin
            logic [3:0] nd;
            nd = dm;
            for (int b = 0; b < 4; b++) begin
               int dif;
               dif = 0;
               foreach (sh[j]) if (sh[j][b] != dm[b]) dif++;
               if (dif == DB) nd[b] = ~dm[b];
            end
            dm = nd;
         end
         ms2 = ms1;
         ms1 = botoes;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic test_reset;
      int t0;
      bit seen;
      cycles(3);
      n_total++; if ({jogada, tem_jogada, jogada_invalida, ocupado, db_estado} !== 10'b0) $display("FAIL reset_initial outputs=%b required=0", {jogada, tem_jogada, jogada_invalida, ocupado, db_estado}); else n_pass++;
      reset = 1'b1;
      cycles(2);
      habilita = 1'b1;
      botoes = 4'b0100;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clock);
         if (tem_jogada) seen = 1'b1;
      end
      n_total++; if (!seen) $display("FAIL reset_reach_emite timeout waiting for tem_jogada"); else n_pass++;
      reset = 1'b0;
      #1;
      n_total++; if (tem_jogada !== 1'b0) $display("FAIL reset_async_tem got=%b required=0", tem_jogada); else n_pass++;
      n_total++; if (jogada !== 4'b0000) $display("FAIL reset_async_jogada got=%b required=0000", jogada); else n_pass++;
      n_total++; if (ocupado !== 1'b0 || jogada_invalida !== 1'b0) $display("FAIL reset_async_flags ocupado=%b inv=%b required=0,0", ocupado, jogada_invalida); else n_pass++;
      n_total++; if (db_estado !== 3'b000) $display("FAIL reset_async_estado got=%b required=000", db_estado); else n_pass++;
      habilita = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      t0 = tem_cnt;
      cycles(30);
      habilita = 1'b1;
      cycles(20);
      n_total++; if (tem_cnt - t0 !== 0) $display("FAIL reset_held_no_strobe got=%0d required=0", tem_cnt - t0); else n_pass++;
      n_total++; if (db_estado !== 3'b011) $display("FAIL reset_held_estado got=%b required=011", db_estado); else n_pass++;
      botoes = 4'b0000;
      cycles(15);
      botoes = 4'b0100;
      cycles(20);
      n_total++; if (tem_cnt - t0 !== 1) $display("FAIL reset_fresh_press strobes=%0d required=1", tem_cnt - t0); else n_pass++;
      n_total++; if (jogada !== 4'b0100) $display("FAIL reset_fresh_jogada got=%b required=0100", jogada); else n_pass++;
      botoes = 4'b0000;
      cycles(15);
   endtask

   task automatic test_clean_press;
      habilita = 1'b1;
      botoes = 4'b0010;
      for (int k = 0; k < 100; k++) begin
         @(negedge clock);
         n_total++; if (tem_jogada !== (k == 6)) $display("FAIL clean_tem edge=%0d got=%b required=%b", k, tem_jogada, k == 6); else n_pass++;
         n_total++; if (jogada !== ((k >= 6) ? 4'b0010 : 4'b0100)) $display("FAIL clean_jogada edge=%0d got=%b", k, jogada); else n_pass++;
         n_total++; if (ocupado !== (k >= 6)) $display("FAIL clean_ocupado edge=%0d got=%b required=%b", k, ocupado, k >= 6); else n_pass++;
      end
      botoes = 4'b0000;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         n_total++; if (ocupado !== (k < 6)) $display("FAIL release_ocupado edge=%0d got=%b required=%b", k, ocupado, k < 6); else n_pass++;
         n_total++; if (jogada !== 4'b0010 || tem_jogada !== 1'b0) $display("FAIL release_hold edge=%0d jogada=%b tem=%b required=0010,0", k, jogada, tem_jogada); else n_pass++;
      end
   endtask

   task automatic test_bounce;
      habilita = 1'b1;
      for (int t = 0; t < 30; t++) begin
         botoes = (t < 20 && ((t / 2) % 2 == 0)) ? 4'b0001 : 4'b0000;
         @(negedge clock);
         n_total++; if (tem_jogada !== 1'b0 || jogada_invalida !== 1'b0) $display("FAIL bounce_strobe t=%0d tem=%b inv=%b required=0,0", t, tem_jogada, jogada_invalida); else n_pass++;
         n_total++; if (db_estado !== 3'b000 || jogada !== 4'b0010) $display("FAIL bounce_state t=%0d estado=%b jogada=%b required=000,0010", t, db_estado, jogada); else n_pass++;
      end
   endtask

   task automatic test_invalid;
      int t0, i0;
      t0 = tem_cnt; i0 = inv_cnt;
      botoes = 4'b0101;
      cycles(50);
      n_total++; if (inv_cnt - i0 !== 1) $display("FAIL invalid_pulses got=%0d required=1", inv_cnt - i0); else n_pass++;
      n_total++; if (tem_cnt - t0 !== 0) $display("FAIL invalid_no_tem got=%0d required=0", tem_cnt - t0); else n_pass++;
      n_total++; if (jogada !== 4'b0010) $display("FAIL invalid_jogada_hold got=%b required=0010", jogada); else n_pass++;
      botoes = 4'b0000;
      cycles(20);
      botoes = 4'b1000;
      cycles(30);
      n_total++; if (tem_cnt - t0 !== 1) $display("FAIL invalid_then_press strobes=%0d required=1", tem_cnt - t0); else n_pass++;
      n_total++; if (jogada !== 4'b1000) $display("FAIL invalid_then_jogada got=%b required=1000", jogada); else n_pass++;
      botoes = 4'b0000;
      cycles(20);
   endtask

   task automatic test_disabled;
      int t0;
      t0 = tem_cnt;
      habilita = 1'b0;
      botoes = 4'b0001;
      cycles(20);
      habilita = 1'b1;
      cycles(30);
      n_total++; if (tem_cnt - t0 !== 0) $display("FAIL disabled_no_strobe got=%0d required=0", tem_cnt - t0); else n_pass++;
      n_total++; if (ocupado !== 1'b1 || db_estado !== 3'b011) $display("FAIL disabled_wait ocupado=%b estado=%b required=1,011", ocupado, db_estado); else n_pass++;
      botoes = 4'b0000;
      cycles(20);
      botoes = 4'b0001;
      cycles(30);
      n_total++; if (tem_cnt - t0 !== 1) $display("FAIL disabled_repress strobes=%0d required=1", tem_cnt - t0); else n_pass++;
      n_total++; if (jogada !== 4'b0001) $display("FAIL disabled_jogada got=%b required=0001", jogada); else n_pass++;
      botoes = 4'b0000;
      cycles(20);
   endtask

   task automatic test_back_to_back;
      logic [3:0] seq [4];
      int t0, i0;
      seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
      t0 = tem_cnt; i0 = inv_cnt;
      codes.delete();
      habilita = 1'b1;
      for (int p = 0; p < 4; p++) begin
         botoes = seq[p];
         cycles(100);
         botoes = 4'b0000;
         cycles(100);
      end
      n_total++; if (tem_cnt - t0 !== 4) $display("FAIL b2b_count got=%0d required=4", tem_cnt - t0); else n_pass++;
      n_total++; if (inv_cnt - i0 !== 0) $display("FAIL b2b_invalid got=%0d required=0", inv_cnt - i0); else n_pass++;
      for (int p = 0; p < 4; p++) begin
         n_total++;
         if (p >= codes.size()) $display("FAIL b2b_code idx=%0d missing required=%b", p, seq[p]);
         else if (codes[p] !== seq[p]) $display("FAIL b2b_code idx=%0d got=%b required=%b", p, codes[p], seq[p]);
         else n_pass++;
      end
   endtask

   task automatic test_random;
      int cyc;
      cyc = 0;
      while (cyc < 3000) begin
         int r, dur;
         r = $urandom_range(0, 9);
         if (r < 5)      botoes = 4'(1 << $urandom_range(0, 3));
         else if (r < 7) botoes = 4'($urandom_range(1, 15));
         else            botoes = 4'b0000;
         habilita = ($urandom_range(0, 4) != 0);
         dur = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 8);
         for (int t = 0; t < dur; t++) begin
            @(negedge clock);
            cyc++;
            n_total++; if (tem_jogada !== m_tem) $display("FAIL rand_tem cyc=%0d got=%b required=%b", cyc, tem_jogada, m_tem); else n_pass++;
            n_total++; if (jogada_invalida !== m_inv) $display("FAIL rand_inv cyc=%0d got=%b required=%b", cyc, jogada_invalida, m_inv); else n_pass++;
            n_total++; if (jogada !== m_jog) $display("FAIL rand_jogada cyc=%0d got=%b required=%b", cyc, jogada, m_jog); else n_pass++;
            n_total++; if (ocupado !== (m_wait | m_tem | m_inv)) $display("FAIL rand_ocupado cyc=%0d got=%b required=%b", cyc, ocupado, m_wait | m_tem | m_inv); else n_pass++;
         end
      end
      botoes = 4'b0000;
      cycles(20);
      n_total++; if (viol !== 0) $display("FAIL strobe_exclusive violations=%0d required=0", viol); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_invalid();
      test_disabled();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
